// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: E-stage operand/result bundle of the multiply/divide unit.
// master = E-stage/pipeline side, slave = the MDU itself.
interface mult_div_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [10:0] instructionID;
    logic        flush;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] result;

    modport master (
        output A, B, instructionID, flush,
        input  start, busy, HI, LO, result
    );

    modport slave (
        input  A, B, instructionID, flush,
        output start, busy, HI, LO, result
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multi-cycle mult/div unit owning HI/LO.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulate ops.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam logic [10:0] ID_MULT  = 11'd20;
    localparam logic [10:0] ID_MULTU = 11'd21;
    localparam logic [10:0] ID_DIV   = 11'd22;
    localparam logic [10:0] ID_DIVU  = 11'd23;
    localparam logic [10:0] ID_MFHI  = 11'd24;
    localparam logic [10:0] ID_MFLO  = 11'd25;
    localparam logic [10:0] ID_MTHI  = 11'd26;
    localparam logic [10:0] ID_MTLO  = 11'd27;
`ifdef MDU_MADD_EN
    localparam logic [10:0] ID_MADD  = 11'd28;
    localparam logic [10:0] ID_MADDU = 11'd29;
    localparam logic [10:0] ID_MSUB  = 11'd30;
    localparam logic [10:0] ID_MSUBU = 11'd31;
`endif

    localparam int MAX_CYC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d;
    logic [31:0]      tmp_lo_q, tmp_lo_d;

    logic op_mult, op_multu, op_div, op_divu;
    logic op_mfhi, op_mflo, op_mthi, op_mtlo;
    logic op_madd, op_maddu, op_msub, op_msubu;
    logic is_mul, is_div, idle;

    logic [63:0]        a_sx, b_sx, a_zx, b_zx;
    logic [63:0]        prod_s, prod_u, hilo, tmp_calc;
    logic               b_zero, div_ovf;
    logic [31:0]        div_bs, div_bu;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;

    // Decode the E-stage instruction into one-hot op flags
    always_comb begin
        op_mult  = 1'b0;
        op_multu = 1'b0;
        op_div   = 1'b0;
        op_divu  = 1'b0;
        op_mfhi  = 1'b0;
        op_mflo  = 1'b0;
        op_mthi  = 1'b0;
        op_mtlo  = 1'b0;
        op_madd  = 1'b0;
        op_maddu = 1'b0;
        op_msub  = 1'b0;
        op_msubu = 1'b0;
        case (bus.instructionID)
            ID_MULT:  op_mult  = 1'b1;
            ID_MULTU: op_multu = 1'b1;
            ID_DIV:   op_div   = 1'b1;
            ID_DIVU:  op_divu  = 1'b1;
            ID_MFHI:  op_mfhi  = 1'b1;
            ID_MFLO:  op_mflo  = 1'b1;
            ID_MTHI:  op_mthi  = 1'b1;
            ID_MTLO:  op_mtlo  = 1'b1;
`ifdef MDU_MADD_EN
            ID_MADD:  op_madd  = 1'b1;
            ID_MADDU: op_maddu = 1'b1;
            ID_MSUB:  op_msub  = 1'b1;
            ID_MSUBU: op_msubu = 1'b1;
`endif
            default: ;
        endcase
    end

    assign is_mul = op_mult | op_multu | op_madd |
                    op_maddu | op_msub | op_msubu;
    assign is_div = op_div | op_divu;
    assign idle   = (state_q == S_IDLE);

    assign bus.start  = (is_mul | is_div) & idle & ~bus.flush;
    assign bus.busy   = ~idle;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.result = op_mfhi ? hi_q :
                        op_mflo ? lo_q : 32'b0;

    assign a_sx   = {{32{bus.A[31]}}, bus.A};
    assign b_sx   = {{32{bus.B[31]}}, bus.B};
    assign a_zx   = {32'b0, bus.A};
    assign b_zx   = {32'b0, bus.B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign hilo   = {hi_q, lo_q};

    // Divisor of 1 replaces /0 and INT_MIN/-1: the zero case keeps
    // HI/LO anyway, and INT_MIN/1 yields the wrapped quotient, rem 0.
    assign b_zero  = (bus.B == 32'b0);
    assign div_ovf = (bus.A == 32'h8000_0000) &&
                     (bus.B == 32'hFFFF_FFFF);
    assign div_bs  = (b_zero || div_ovf) ? 32'd1 : bus.B;
    assign div_bu  = b_zero ? 32'd1 : bus.B;
    assign quo_s   = $signed(bus.A) / $signed(div_bs);
    assign rem_s   = $signed(bus.A) % $signed(div_bs);
    assign quo_u   = bus.A / div_bu;
    assign rem_u   = bus.A % div_bu;

    // Select the 64-bit value parked in tmpHI/tmpLO at start
    always_comb begin
        tmp_calc = hilo;
        if (op_mult)
            tmp_calc = prod_s;
        else if (op_multu)
            tmp_calc = prod_u;
        else if (op_madd)
            tmp_calc = hilo + prod_s;
        else if (op_maddu)
            tmp_calc = hilo + prod_u;
        else if (op_msub)
            tmp_calc = hilo - prod_s;
        else if (op_msubu)
            tmp_calc = hilo - prod_u;
        else if (op_div)
            tmp_calc = b_zero ? hilo : {rem_s, quo_s};
        else if (op_divu)
            tmp_calc = b_zero ? hilo : {rem_u, quo_u};
    end

    // Next-state: launch, count down, commit on the last busy cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tmp_hi_d = tmp_calc[63:32];
                    tmp_lo_d = tmp_calc[31:0];
                    if (is_mul) begin
                        state_d = S_MUL;
                        cnt_d   = CNT_W'(MULT_CYCLES);
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = CNT_W'(DIV_CYCLES);
                    end
                end else if (!bus.flush) begin
                    if (op_mthi) hi_d = bus.A;
                    if (op_mtlo) lo_d = bus.A;
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, HI/LO and parked result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
        end
    end
endmodule
